// File: rtl/stat_display_pkg.sv
// Shared definitions for the statistics display: source selects, segment
// constants, the hex glyph table and the converter state type.
package stat_display_pkg;

    typedef enum logic [2:0] {
        SEL_SYSCALL = 3'd0,
        SEL_TOTAL   = 3'd1,
        SEL_UNCOND  = 3'd2,
        SEL_COND    = 3'd3,
        SEL_CONDSUC = 3'd4
    } sel_t;

    typedef enum logic {
        CONV_IDLE,
        CONV_RUN
    } conv_state_t;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_DASH  = 8'hBF;
    localparam logic [7:0] SEG_ZERO  = 8'hC0;

    // Active-low segments, bit 7 = dp (always off), bits 6:0 = g..a.
    function automatic logic [7:0] hex_glyph(input logic [3:0] nib);
        logic [7:0] g;
        case (nib)
            4'h0: g = 8'hC0;
            4'h1: g = 8'hF9;
            4'h2: g = 8'hA4;
            4'h3: g = 8'hB0;
            4'h4: g = 8'h99;
            4'h5: g = 8'h92;
            4'h6: g = 8'h82;
            4'h7: g = 8'hF8;
            4'h8: g = 8'h80;
            4'h9: g = 8'h90;
            4'hA: g = 8'h88;
            4'hB: g = 8'h83;
            4'hC: g = 8'hC6;
            4'hD: g = 8'hA1;
            4'hE: g = 8'h86;
            default: g = 8'h8E;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/stat_display_bin2bcd.sv
// Sequential shift-add-3 binary to BCD converter: one input bit per cycle,
// 32 busy cycles, result and overflow flag published on the final step.
module bin2bcd_seq
    import stat_display_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] value,
    output logic        busy,
    output logic [31:0] bcd,
    output logic        overflow
);

    conv_state_t state, state_next;
    logic [31:0] shreg;
    logic [31:0] work;
    logic [31:0] adj;
    logic [31:0] work_next;
    logic [4:0]  bit_cnt;
    logic        ovf_work;

    // Only the low eight digits are kept; larger values are flagged as overflow.
    always_comb begin
        adj = work;
        for (int unsigned i = 0; i < 8; i++) begin
            if (work[4*i +: 4] >= 4'd5) adj[4*i +: 4] = work[4*i +: 4] + 4'd3;
        end
        work_next = 32'({adj, shreg[31]});
    end

    always_comb begin
        state_next = state;
        case (state)
            CONV_IDLE: if (start) state_next = CONV_RUN;
            CONV_RUN:  if (bit_cnt == 5'd31) state_next = CONV_IDLE;
            default:   state_next = CONV_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= CONV_IDLE;
        else     state <= state_next;
    end

    assign busy = (state == CONV_RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg    <= '0;
            work     <= '0;
            bit_cnt  <= '0;
            ovf_work <= 1'b0;
            bcd      <= '0;
            overflow <= 1'b0;
        end else if (state == CONV_IDLE) begin
            if (start) begin
                shreg    <= value;
                work     <= '0;
                bit_cnt  <= '0;
                ovf_work <= (value > 32'd99_999_999);
            end
        end else begin
            shreg   <= shreg << 1;
            work    <= work_next;
            bit_cnt <= bit_cnt + 5'd1;
            if (bit_cnt == 5'd31) begin
                bcd      <= work_next;
                overflow <= ovf_work;
            end
        end
    end

endmodule

// File: rtl/stat_display.sv
// Multiplexed 8-digit statistics display with snapshot, freeze and halt hold.
// Define STAT_DISPLAY_DEC_EN for decimal output through bin2bcd_seq.
module stat_display
    import stat_display_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] total_cycles,
    input  logic [31:0] uncondi_num,
    input  logic [31:0] condi_num,
    input  logic [31:0] condi_suc_num,
    input  logic [31:0] SyscallOut,
    input  logic        halt,
    input  logic [2:0]  sel,
    input  logic        freeze,
    output logic [7:0]  an,
    output logic [7:0]  seg,
    output logic        busy
);

    localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);

    logic          halt_seen;
    logic [31:0]   snap;
    logic          blank;
    logic [CW-1:0] scan_cnt;
    logic [2:0]    idx;
    logic [31:0]   sel_val;
    logic          sel_blank;
    logic [7:0]    seg_next;

    always_comb begin
        sel_val   = '0;
        sel_blank = 1'b0;
        case (sel)
            SEL_SYSCALL: sel_val = SyscallOut;
            SEL_TOTAL:   sel_val = total_cycles;
            SEL_UNCOND:  sel_val = uncondi_num;
            SEL_COND:    sel_val = condi_num;
            SEL_CONDSUC: sel_val = condi_suc_num;
            default:     sel_blank = 1'b1;
        endcase
    end

    // halt_seen is registered, so the halting cycle itself still loads snap.
    always_ff @(posedge clk) begin
        if (rst) begin
            halt_seen <= 1'b0;
            snap      <= '0;
            blank     <= 1'b0;
        end else begin
            if (halt) halt_seen <= 1'b1;
            if (!freeze && !halt_seen) begin
                snap  <= sel_val;
                blank <= sel_blank;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt <= '0;
            idx      <= '0;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            idx      <= idx + 3'd1;
        end else begin
            scan_cnt <= scan_cnt + CW'(1);
        end
    end

`ifdef STAT_DISPLAY_DEC_EN
    logic [31:0] last_val;
    logic [31:0] bcd;
    logic        ovf;
    logic        conv_start;

    assign conv_start = !busy && (snap != last_val);

    always_ff @(posedge clk) begin
        if (rst)             last_val <= '0;
        else if (conv_start) last_val <= snap;
    end

    bin2bcd_seq u_bin2bcd (
        .clk      (clk),
        .rst      (rst),
        .start    (conv_start),
        .value    (snap),
        .busy     (busy),
        .bcd      (bcd),
        .overflow (ovf)
    );

    always_comb begin
        seg_next = hex_glyph(bcd[{idx, 2'b00} +: 4]);
        if (ovf)   seg_next = SEG_DASH;
        if (blank) seg_next = SEG_BLANK;
    end
`else
    assign busy = 1'b0;

    always_comb begin
        seg_next = hex_glyph(snap[{idx, 2'b00} +: 4]);
        if (blank) seg_next = SEG_BLANK;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            an  <= 8'hFE;
            seg <= SEG_ZERO;
        end else begin
            an  <= ~(8'h01 << idx);
            seg <= seg_next;
        end
    end

endmodule

// File: tb/tb_stat_display.sv
// Self-checking bench for stat_display: vector table, directed corner cases
// and a randomized run against a cycle-level reference model.
module tb_stat_display;

    localparam int unsigned SCAN_DIV = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] total_cycles = '0, uncondi_num = '0, condi_num = '0;
    logic [31:0] condi_suc_num = '0, SyscallOut = '0;
    logic        halt = 1'b0;
    logic [2:0]  sel = 3'd0;
    logic        freeze = 1'b0;
    logic [7:0]  an, seg;
    logic        busy;

    int checks = 0;
    int failures = 0;

    stat_display #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk(clk), .rst(rst), .total_cycles(total_cycles), .uncondi_num(uncondi_num),
        .condi_num(condi_num), .condi_suc_num(condi_suc_num), .SyscallOut(SyscallOut),
        .halt(halt), .sel(sel), .freeze(freeze), .an(an), .seg(seg), .busy(busy)
    );

    always #5 clk = ~clk;

    logic [7:0] glyph_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                   8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] pick_src(input logic [2:0] s);
        case (s)
            3'd0: return SyscallOut;
            3'd1: return total_cycles;
            3'd2: return uncondi_num;
            3'd3: return condi_num;
            3'd4: return condi_suc_num;
            default: return 32'd0;
        endcase
    endfunction

    // Expected glyph for digit d of a held value, computed arithmetically.
    function automatic logic [7:0] exp_seg(input logic [31:0] v, input logic bl, input int d);
        logic [3:0] nib;
        longint unsigned p;
        if (bl) return 8'hFF;
`ifdef STAT_DISPLAY_DEC_EN
        if (v > 32'd99_999_999) return 8'hBF;
        p = 1;
        for (int i = 0; i < d; i++) p = p * 10;
        nib = 4'(({32'd0, v} / p) % 10);
`else
        p = 0;
        nib = 4'(v >> (4 * d));
`endif
        return glyph_tab[nib];
    endfunction

    // Reference model: digit position from elapsed cycles, snapshot from the rules.
    int unsigned m_edges;
    logic [31:0] m_snap;
    logic        m_blank, m_halt;
    logic [7:0]  m_an, m_seg;
    logic        chk_on = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_edges <= 0; m_snap <= '0; m_blank <= 1'b0; m_halt <= 1'b0;
            m_an <= 8'hFE; m_seg <= 8'hC0;
        end else begin
            m_edges <= m_edges + 1;
            m_an    <= ~(8'h01 << ((m_edges / SCAN_DIV) % 8));
            m_seg   <= m_blank ? 8'hFF : glyph_tab[4'(m_snap >> (4 * ((m_edges / SCAN_DIV) % 8)))];
            if (halt) m_halt <= 1'b1;
            if (!freeze && !m_halt) begin
                m_snap  <= pick_src(sel);
                m_blank <= (sel > 3'd4);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("an_model", {24'd0, an}, {24'd0, m_an});
`ifndef STAT_DISPLAY_DEC_EN
            check("seg_model", {24'd0, seg}, {24'd0, m_seg});
            check("busy_hex", {31'd0, busy}, 32'd0);
`endif
        end
    end

    task automatic do_reset();
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); @(negedge clk);
        check("rst_an", {24'd0, an}, 32'hFE);
        check("rst_seg", {24'd0, seg}, 32'hC0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1; rst = 1'b0;
    endtask

    task automatic capture(input string name, input logic [31:0] v, input logic bl);
        logic [7:0] got [8];
        logic [7:0] seen;
        int z;
        repeat (3) @(posedge clk);
`ifdef STAT_DISPLAY_DEC_EN
        begin
            int n = 0;
            while (busy === 1'b1 && n < 200) begin @(posedge clk); n++; end
            check({name, "_conv_timeout"}, n, (n < 200) ? n : 0);
        end
        repeat (2) @(posedge clk);
`endif
        seen = '0;
        for (int d = 0; d < 8; d++) got[d] = 8'h00;
        for (int c = 0; c < 8 * SCAN_DIV; c++) begin
            @(negedge clk);
            z = 8;
            for (int d = 0; d < 8; d++) if (an == ~(8'h01 << d)) z = d;
            if (z < 8) begin seen[z] = 1'b1; got[z] = seg; end
        end
        check({name, "_scan"}, {24'd0, seen}, 32'hFF);
        for (int d = 0; d < 8; d++)
            check($sformatf("%s_d%0d", name, d), {24'd0, got[d]}, {24'd0, exp_seg(v, bl, d)});
    endtask

    typedef struct {
        logic [2:0]  sel;
        logic [31:0] sys, tot, unc, con, suc;
        logic [31:0] exp_val;
        logic        exp_blank;
    } vec_t;

    vec_t vecs [8];
    logic [7:0] walk_an  [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
    logic [7:0] walk_seg [8] = '{8'hA1, 8'hC6, 8'h83, 8'h88, 8'h99, 8'hB0, 8'hA4, 8'hF9};

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{3'd0, 32'h00000042, 32'h11111111, 32'h02222222, 32'h03333333, 32'h04444444, 32'h00000042, 1'b0};
        vecs[1] = '{3'd1, 32'h00000042, 32'h00987654, 32'h02222222, 32'h03333333, 32'h04444444, 32'h00987654, 1'b0};
        vecs[2] = '{3'd2, 32'h00000017, 32'h00987654, 32'h00C0FFEE, 32'h03333333, 32'h04444444, 32'h00C0FFEE, 1'b0};
        vecs[3] = '{3'd3, 32'h00000017, 32'h00987654, 32'h00C0FFEE, 32'h05F5E0FF, 32'h04444444, 32'h05F5E0FF, 1'b0};
        vecs[4] = '{3'd4, 32'h00000017, 32'h00987654, 32'h00C0FFEE, 32'h05F5E0FF, 32'h05F5E100, 32'h05F5E100, 1'b0};
        vecs[5] = '{3'd6, 32'h00000017, 32'h00987654, 32'h00C0FFEE, 32'h05F5E0FF, 32'h05F5E100, 32'h00000000, 1'b1};
        vecs[6] = '{3'd1, 32'h00000017, 32'hFFFFFFFF, 32'h00C0FFEE, 32'h05F5E0FF, 32'h05F5E100, 32'hFFFFFFFF, 1'b0};
        vecs[7] = '{3'd7, 32'h00000017, 32'h00987654, 32'h00C0FFEE, 32'h05F5E0FF, 32'h05F5E100, 32'h00000000, 1'b1};

        // Scan walk: value loaded on the first edge after reset.
        sel = 3'd1; total_cycles = 32'h1234ABCD;
        do_reset();
        chk_on = 1'b1;
        for (int n = 1; n <= 32; n++) begin
            @(posedge clk); @(negedge clk);
            if (n % 4 == 0) begin
                check($sformatf("walk_an%0d", n / 4 - 1), {24'd0, an}, {24'd0, walk_an[n / 4 - 1]});
`ifdef STAT_DISPLAY_DEC_EN
                check($sformatf("walk_seg%0d", n / 4 - 1), {24'd0, seg}, 32'hBF);
`else
                check($sformatf("walk_seg%0d", n / 4 - 1), {24'd0, seg}, {24'd0, walk_seg[n / 4 - 1]});
`endif
            end
        end

        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            sel = vecs[i].sel; SyscallOut = vecs[i].sys; total_cycles = vecs[i].tot;
            uncondi_num = vecs[i].unc; condi_num = vecs[i].con; condi_suc_num = vecs[i].suc;
            capture($sformatf("vec%0d", i), vecs[i].exp_val, vecs[i].exp_blank);
        end

        // Halt pulse freezes the snapshot until reset.
        @(posedge clk); #1; sel = 3'd0; SyscallOut = 32'd5;
        @(posedge clk); #1; halt = 1'b1;
        @(posedge clk); #1; halt = 1'b0; SyscallOut = 32'd9;
        capture("halt_hold", 32'd5, 1'b0);
        do_reset();
        capture("halt_cleared", 32'd9, 1'b0);

        // Freeze holds, release shows the new value.
        @(posedge clk); #1; sel = 3'd1; total_cycles = 32'd100;
        capture("frz_pre", 32'd100, 1'b0);
        @(posedge clk); #1; freeze = 1'b1;
        @(posedge clk); #1; total_cycles = 32'd200;
        capture("frz_hold", 32'd100, 1'b0);
        @(posedge clk); #1; freeze = 1'b0;
        capture("frz_rel", 32'd200, 1'b0);

`ifdef STAT_DISPLAY_DEC_EN
        begin
            int n, len;
            do_reset();
            sel = 3'd0; SyscallOut = 32'd12345678;
            n = 0;
            while (busy !== 1'b1 && n < 10) begin @(negedge clk); n++; end
            check("dec_busy_rise", {31'd0, busy}, 32'd1);
            len = 0;
            while (busy === 1'b1 && len < 100) begin @(negedge clk); len++; end
            check("dec_busy_len", len, 32);
            capture("dec_1234", 32'd12345678, 1'b0);
            @(posedge clk); #1; SyscallOut = 32'd99_999_999;
            capture("dec_max", 32'd99_999_999, 1'b0);
            @(posedge clk); #1; SyscallOut = 32'd100_000_000;
            capture("dec_ovf", 32'd100_000_000, 1'b0);
            @(posedge clk); #1; SyscallOut = 32'd87654321;
            n = 0;
            while (busy !== 1'b1 && n < 10) begin @(negedge clk); n++; end
            check("abort_busy_rise", {31'd0, busy}, 32'd1);
            repeat (9) @(negedge clk);
            @(posedge clk); #1; rst = 1'b1;
            @(negedge clk);
            check("abort_busy", {31'd0, busy}, 32'd0);
            check("abort_an", {24'd0, an}, 32'hFE);
            check("abort_seg", {24'd0, seg}, 32'hC0);
            @(posedge clk); #1; rst = 1'b0;
            capture("abort_redo", 32'd87654321, 1'b0);
        end
`endif

        // Randomized run against the reference model.
        for (int cyc = 0; cyc < 1500; cyc++) begin
            @(posedge clk); #1;
            rst  = ($urandom_range(0, 199) == 0);
            halt = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 7) == 0) sel = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 15) == 0) freeze = ~freeze;
            total_cycles  = $urandom();
            uncondi_num   = $urandom();
            condi_num     = $urandom();
            condi_suc_num = $urandom();
            if ($urandom_range(0, 3) == 0) SyscallOut = $urandom();
        end
        @(posedge clk); #1; rst = 1'b0; halt = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
